shift_arbiter: RTL and testbench

Round-robin arbiter that shares one 8-bit barrel shifter (the team's `Shifter`: left and right logical shift by 0–7) among NREQ requesters. Each requester presents a data byte, shift amount and direction over a valid/ready handshake. One request is accepted per cycle and shifted. The result is registered and returned with the requester's ID over a valid/ready response port. The block sits between the shift clients and the shared shifter datapath.

---
 rtl/shift_arbiter_if.sv | 26 ++
 rtl/shift_arbiter.sv | 89 ++++++++
 tb/tb_shift_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between shift clients and the shared shifter arbiter.
// master = client/consumer side, slave = arbiter side.
interface shift_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [3*NREQ-1:0] req_amt;
  logic [NREQ-1:0]   req_dir;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_data;
  logic              rsp_ready;

  modport master (
    output req_valid, req_data, req_amt, req_dir, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_data, req_amt, req_dir, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 8-bit logical barrel shifter among NREQ
// requesters. One request accepted per cycle; the shifted byte and the
// requester ID are returned through a single registered response slot.
module shift_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic            clk,
  input logic            rst,
  shift_arbiter_if.slave bus
);

  logic [IDW-1:0] r_ptr;
  logic           r_rsp_valid;
  logic [IDW-1:0] r_rsp_id;
  logic [7:0]     r_rsp_data;

  logic           w_any;
  logic [IDW-1:0] w_gnt;
  logic           w_can_issue;
  logic           w_accept;
  logic [7:0]     w_sel_data;
  logic [2:0]     w_sel_amt;
  logic           w_sel_dir;
  logic [7:0]     w_result;
  logic [IDW-1:0] w_ptr_next;

  assign w_can_issue = !r_rsp_valid || bus.rsp_ready;
  assign w_accept    = w_any && w_can_issue && !rst;

  // Search from r_ptr upward with wrap; first valid requester wins.
  always_comb begin : grant_search
    logic [IDW:0] idx;
    w_any = 1'b0;
    w_gnt = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (!w_any && bus.req_valid[idx[IDW-1:0]]) begin
        w_any = 1'b1;
        w_gnt = idx[IDW-1:0];
      end
    end
  end

  // Operand mux and shared logical shifter (zero fill, no rotate).
  always_comb begin
    w_sel_data = bus.req_data[8*w_gnt +: 8];
    w_sel_amt  = bus.req_amt[3*w_gnt +: 3];
    w_sel_dir  = bus.req_dir[w_gnt];
    w_result   = w_sel_dir ? (w_sel_data >> w_sel_amt) : (w_sel_data << w_sel_amt);
  end

  // Next pointer: one past the granted requester, wrapping at NREQ-1.
  always_comb begin
    if (w_gnt == IDW'(NREQ - 1)) w_ptr_next = '0;
    else                         w_ptr_next = w_gnt + 1'b1;
  end

  // One-hot ready to the granted requester; held low during reset or stall.
  always_comb begin
    bus.req_ready = '0;
    if (w_accept) bus.req_ready[w_gnt] = 1'b1;
  end

  // Response slot and priority pointer; accept wins over drain so a
  // simultaneous take-and-refill leaves no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else if (w_accept) begin
      r_ptr       <= w_ptr_next;
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_gnt;
      r_rsp_data  <= w_result;
    end else if (r_rsp_valid && bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter (NREQ=4): reset, shift values,
// round-robin rotation, backpressure, skip/wrap and mid-operation reset.
module tb_shift_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  shift_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

  shift_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic [2:0] a, input logic dir);
    bus.req_valid[i]       = 1'b1;
    bus.req_data[8*i +: 8] = d;
    bus.req_amt[3*i +: 3]  = a;
    bus.req_dir[i]         = dir;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 3'd0, 1'b0);
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready got=%b exp=%b", bus.req_ready, 4'b0000);
    end
    tick();
    tick();
    n_cmp++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready2 got=%b exp=%b", bus.req_ready, 4'b0000);
    end
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== 11'b0) begin
      n_fail++; $display("FAIL reset_rsp got v=%b id=%0d d=%h exp v=0 id=0 d=00",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL reset_first_gnt got=%b exp=%b", bus.req_ready, 4'b0001);
    end
    tick();
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 8'h01) begin
      n_fail++; $display("FAIL reset_first_rsp got v=%b id=%0d d=%h exp v=1 id=0 d=01",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_shift();
    logic [7:0] vd [10] = '{8'hFB, 8'hFB, 8'hF1, 8'hF1, 8'hE7, 8'hBF, 8'h5B, 8'h5B, 8'hA5, 8'hA5};
    logic [2:0] va [10] = '{3'd4, 3'd4, 3'd2, 3'd2, 3'd1, 3'd3, 3'd7, 3'd7, 3'd0, 3'd0};
    logic       vr [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] ve [10] = '{8'hB0, 8'h0F, 8'hC4, 8'h3C, 8'hCE, 8'h17, 8'h80, 8'h00, 8'hA5, 8'hA5};
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.req_valid = '0;
      set_req(k % 4, vd[k], va[k], vr[k]);
      #1;
      n_cmp++;
      if (bus.req_ready !== 4'(1 << (k % 4))) begin
        n_fail++; $display("FAIL shift_ready[%0d] got=%b exp=%b", k, bus.req_ready, 4'(1 << (k % 4)));
      end
      tick();
      bus.req_valid = '0;
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(k % 4) || bus.rsp_data !== ve[k]) begin
        n_fail++; $display("FAIL shift[%0d] got v=%b id=%0d d=%h exp v=1 id=%0d d=%h",
                           k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, k % 4, ve[k]);
      end
    end
    tick();
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'hA5 || bus.rsp_id !== 2'd1) begin
      n_fail++; $display("FAIL drain_hold got v=%b id=%0d d=%h exp v=0 id=1 d=a5",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] ex [4] = '{8'h02, 8'h40, 8'hF0, 8'h07};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    set_req(0, 8'h81, 3'd1, 1'b0);
    set_req(1, 8'h81, 3'd1, 1'b1);
    set_req(2, 8'h3C, 3'd2, 1'b0);
    set_req(3, 8'h3C, 3'd3, 1'b1);
    for (int k = 0; k < 8; k++) begin
      #1;
      n_cmp++;
      if (bus.req_ready !== 4'(1 << (k % 4))) begin
        n_fail++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, bus.req_ready, 4'(1 << (k % 4)));
      end
      tick();
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(k % 4) || bus.rsp_data !== ex[k % 4]) begin
        n_fail++; $display("FAIL rr[%0d] got v=%b id=%0d d=%h exp v=1 id=%0d d=%h",
                           k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, k % 4, ex[k % 4]);
      end
    end
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (bus.req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, bus.req_ready);
      end
      tick();
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 || bus.rsp_data !== 8'h07) begin
        n_fail++; $display("FAIL bp_hold[%0d] got v=%b id=%0d d=%h exp v=1 id=3 d=07",
                           k, bus.rsp_valid, bus.rsp_id, bus.rsp_data);
      end
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL bp_release_ready got=%b exp=0001", bus.req_ready);
    end
    tick();
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 8'h02) begin
      n_fail++; $display("FAIL bp_nobubble got v=%b id=%0d d=%h exp v=1 id=0 d=02",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_skip_wrap();
    bus.rsp_ready = 1'b1;
    set_req(2, 8'h11, 3'd1, 1'b0);
    tick();
    n_cmp++;
    if (bus.rsp_id !== 2'd2 || bus.rsp_data !== 8'h22) begin
      n_fail++; $display("FAIL sw_setup got id=%0d d=%h exp id=2 d=22", bus.rsp_id, bus.rsp_data);
    end
    bus.req_valid = '0;
    set_req(1, 8'h80, 3'd7, 1'b1);
    set_req(2, 8'h01, 3'd7, 1'b0);
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL sw_wrap_ready got=%b exp=0010", bus.req_ready);
    end
    tick();
    n_cmp++;
    if (bus.rsp_id !== 2'd1 || bus.rsp_data !== 8'h01) begin
      n_fail++; $display("FAIL sw_gnt1 got id=%0d d=%h exp id=1 d=01", bus.rsp_id, bus.rsp_data);
    end
    bus.req_valid[1] = 1'b0;
    tick();
    n_cmp++;
    if (bus.rsp_id !== 2'd2 || bus.rsp_data !== 8'h80) begin
      n_fail++; $display("FAIL sw_gnt2 got id=%0d d=%h exp id=2 d=80", bus.rsp_id, bus.rsp_data);
    end
    bus.req_valid = '0;
    set_req(0, 8'h0F, 3'd4, 1'b0);
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL sw_req0_ready got=%b exp=0001", bus.req_ready);
    end
    tick();
    n_cmp++;
    if (bus.rsp_id !== 2'd0 || bus.rsp_data !== 8'hF0) begin
      n_fail++; $display("FAIL sw_gnt0 got id=%0d d=%h exp id=0 d=f0", bus.rsp_id, bus.rsp_data);
    end
    set_req(3, 8'hF0, 3'd4, 1'b1);
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL sw_ptr1_ready got=%b exp=1000", bus.req_ready);
    end
    tick();
    n_cmp++;
    if (bus.rsp_id !== 2'd3 || bus.rsp_data !== 8'h0F) begin
      n_fail++; $display("FAIL sw_gnt3 got id=%0d d=%h exp id=3 d=0f", bus.rsp_id, bus.rsp_data);
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_mid_reset();
    bus.rsp_ready = 1'b1;
    set_req(1, 8'h03, 3'd1, 1'b0);
    tick();
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== 8'h06) begin
      n_fail++; $display("FAIL mr_pre got v=%b id=%0d d=%h exp v=1 id=1 d=06",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    bus.req_valid = '0;
    set_req(2, 8'h55, 3'd1, 1'b0);
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL mr_ready got=%b exp=0000", bus.req_ready);
    end
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== 11'b0) begin
      n_fail++; $display("FAIL mr_rsp got v=%b id=%0d d=%h exp v=0 id=0 d=00",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 8'(8'h10 + i), 3'd0, 1'b0);
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL mr_ptr0 got=%b exp=0001", bus.req_ready);
    end
    tick();
    n_cmp++;
    if (bus.rsp_id !== 2'd0 || bus.rsp_data !== 8'h10) begin
      n_fail++; $display("FAIL mr_first got id=%0d d=%h exp id=0 d=10", bus.rsp_id, bus.rsp_data);
    end
    bus.req_valid = '0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_amt   = '0;
    bus.req_dir   = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_shift();
    test_round_robin();
    test_backpressure();
    test_skip_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
